// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM state encodings and datapath mux codes for the multicycle MIPS control
package mips_pkg;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath/memory strobes and status
interface multicycle_control_if #(parameter int STATE_W = 4);
  logic [5:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_src;
  logic               illegal_op;
  logic [STATE_W-1:0] state;
  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM sequencing fetch/decode/execute/memory/writeback for the multicycle MIPS
module multicycle_control
  import mips_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int STATE_W       = 4
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);
  state_e r_state, w_next;
  logic   w_rdy, w_legal, w_pc_write, w_branch, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
  assign w_rdy   = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign w_legal = bus.opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE:
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      S_MEMADR:  w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = w_rdy ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end
  always_ff @(posedge clk)
    r_state <= reset ? S_FETCH : w_next;
  always_comb begin
    w_pc_write     = 1'b0;
    w_branch       = 1'b0;
    w_ir_write     = 1'b0;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_reg_write    = 1'b0;
    bus.iord       = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_B;
    bus.alu_op     = ALUOP_ADD;
    bus.pc_src     = PCSRC_ALU;
    case (r_state)
      S_FETCH: begin
        w_mem_read    = 1'b1;
        bus.alu_src_b = SRCB_4;
        w_ir_write    = w_rdy;
        w_pc_write    = w_rdy;
      end
      S_DECODE:  bus.alu_src_b = SRCB_IMM2;
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.iord   = 1'b1;
        w_mem_read = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write    = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        bus.iord    = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_SUB;
        bus.pc_src    = PCSRC_ALUOUT;
        w_branch      = 1'b1;
      end
      S_ADDIWB:  w_reg_write = 1'b1;
      S_JUMP: begin
        bus.pc_src = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end
  // side-effecting strobes are suppressed while reset is held, whatever the state
  assign bus.pc_en      = !reset && (w_pc_write || (w_branch && bus.zero));
  assign bus.ir_write   = !reset && w_ir_write;
  assign bus.mem_read   = !reset && w_mem_read;
  assign bus.mem_write  = !reset && w_mem_write;
  assign bus.reg_write  = !reset && w_reg_write;
  assign bus.illegal_op = !reset && (r_state == S_DECODE) && !w_legal;
  assign bus.state      = STATE_W'(r_state);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized check of the control FSM against a per-instruction state-path model
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   m_state;
  int   q[$];
  multicycle_control_if #(.STATE_W(4)) bus ();
  multicycle_control #(.MEM_HANDSHAKE(1'b1), .STATE_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] exp_out(input int s, input logic rst, input logic rdy,
                                          input logic z, input logic [5:0] op);
    logic       pc_en = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, asa = 0, ill = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = rdy; pc_en = rdy; end
      1:  begin asb = 2'b11; ill = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02}); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pc_en = z; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin psrc = 2'b10; pc_en = 1; end
      default: ;
    endcase
    if (rst) {pc_en, irw, rw, mwr, mrd, ill} = '0;
    return {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc, ill};
  endfunction
  task automatic step(input logic rst, input logic rdy, input logic z, input logic [5:0] op);
    logic [15:0] got;
    @(negedge clk);
    if (m_state == 0) bus.opcode = op;
    reset = rst;
    bus.mem_ready = rdy;
    bus.zero = z;
    #1;
    got = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
           bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
           bus.pc_src, bus.illegal_op};
    check("state", int'(bus.state), m_state);
    check("outputs", int'(got), int'(exp_out(m_state, rst, rdy, z, bus.opcode)));
    if (rst) begin
      m_state = 0;
      q.delete();
    end else
      case (m_state)
        0: if (rdy) m_state = 1;
        1: begin
          case (bus.opcode)
            6'h23:   q = {2, 3, 4};
            6'h2B:   q = {2, 5};
            6'h00:   q = {6, 7};
            6'h04:   q = {8};
            6'h08:   q = {9, 10};
            6'h02:   q = {11};
            default: q.delete();
          endcase
          m_state = q.size() > 0 ? q.pop_front() : 0;
        end
        3, 5: if (rdy) m_state = q.size() > 0 ? q.pop_front() : 0;
        default: m_state = q.size() > 0 ? q.pop_front() : 0;
      endcase
  endtask
  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 6'h00;
      1: return 6'h23;
      2: return 6'h2B;
      3: return 6'h04;
      4: return 6'h08;
      5: return 6'h02;
      default: return 6'($urandom);
    endcase
  endfunction
  initial begin
    reset = 1'b1;
    bus.opcode = 6'h23;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    m_state = 0;
    @(posedge clk);
    step(1, 0, 0, 6'h23);
    // walk an LW into MEMRD, stall there, then reset mid-wait
    step(0, 1, 0, 6'h23);
    step(0, 1, 0, 6'h23);
    step(0, 1, 0, 6'h23);
    step(0, 0, 0, 6'h23);
    step(1, 0, 0, 6'h23);
    step(1, 0, 0, 6'h23);
    step(0, 0, 0, 6'h23);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 6'h23);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 6'h2B);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 6'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 6'h04);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 6'h04);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 6'h2B);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 6'h2B);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 6'h2B);
    step(0, 1, 0, 6'h2B);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 6'h3F);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 6'h02);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 1'($urandom), pick_op());
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
